// File: rtl/french_pkg.sv
// ---------------------------------------------------------------------------
// french_pkg
// Shared types and constants for the enemy-object stimulus generator.
//   - dirT      : movement direction as decoded by the mover
//   - stateT    : tick FSM state
//   - baseCode  : first code of each direction band (0/4/8/12)
//   - dirCode   : base code plus a 2-bit jitter taken from the LFSR
//   - lfsrStep  : one Galois right-shift step of the 16-bit LFSR
// ---------------------------------------------------------------------------
package french_pkg;

   localparam int          COORD_W   = 11;
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_RIGHT = 2'd2,
      DIR_LEFT  = 2'd3
   } dirT;

   localparam logic [3:0] CODE_UP    = 4'd0;
   localparam logic [3:0] CODE_DOWN  = 4'd4;
   localparam logic [3:0] CODE_RIGHT = 4'd8;
   localparam logic [3:0] CODE_LEFT  = 4'd12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DRAW  = 2'd2,
      FIRE  = 2'd3
   } stateT;

   function automatic logic [3:0] baseCode(input dirT dir);
      logic [3:0] code;
      case (dir)
         DIR_UP:    code = CODE_UP;
         DIR_DOWN:  code = CODE_DOWN;
         DIR_RIGHT: code = CODE_RIGHT;
         default:   code = CODE_LEFT;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] dirCode(input dirT dir, input logic [1:0] jitter);
      return baseCode(dir) + {2'b00, jitter};
   endfunction

   function automatic logic [15:0] lfsrStep(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/french_lfsr16.sv
// ---------------------------------------------------------------------------
// french_lfsr16
// Free-running 16-bit Galois LFSR with a synchronous seed load.
// A zero seed is replaced by SEED so the register can never lock up at 0.
// Ports:
//   CLK, RESETn   : clock, asynchronous active-low reset
//   seed_load_i   : load seed_i this cycle instead of advancing
//   seed_i [15:0] : seed value
//   lfsr_o [15:0] : current LFSR state
// ---------------------------------------------------------------------------
module french_lfsr16
   import french_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        seed_load_i,
   input  logic [15:0] seed_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Advance every cycle; a seed load takes priority over the step.
   always_comb begin
      lfsr_d = lfsrStep(lfsr_q);
      if (seed_load_i) begin
         lfsr_d = (seed_i == 16'h0000) ? SEED : seed_i;
      end
   end

   // LFSR state register.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/french_stim_gen.sv
// ---------------------------------------------------------------------------
// french_stim_gen
// Produces the periodic timer_done strobe and 4-bit random direction code
// consumed by the enemy-object mover (0-3 UP, 4-7 DOWN, 8-11 RIGHT, 12-15 LEFT).
// Optional chase mode: define FRENCH_CHASE_EN to bias draws toward the frog.
// Ports:
//   CLK, RESETn          : clock, asynchronous active-low reset
//   enable               : game running; low freezes tick generation
//   seed_load, seed_in   : one-cycle LFSR seed load
//   frog_x/y, obj_x/y    : coordinates (used only in chase mode)
//   timer_done           : one-cycle tick strobe, every TICK_DIV cycles
//   random               : direction code, changes only with timer_done
// ---------------------------------------------------------------------------
module french_stim_gen
   import french_pkg::*;
#(
   parameter int          TICK_DIV  = 833333,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          CHASE_NUM = 3
) (
   input  logic               CLK,
   input  logic               RESETn,
   input  logic               enable,
   input  logic               seed_load,
   input  logic [15:0]        seed_in,
   input  logic [COORD_W-1:0] frog_x,
   input  logic [COORD_W-1:0] frog_y,
   input  logic [COORD_W-1:0] obj_x,
   input  logic [COORD_W-1:0] obj_y,
   output logic               timer_done,
   output logic [3:0]         random
);

   // COUNT lasts TICK_DIV-2 cycles, DRAW and FIRE one each: period TICK_DIV.
   localparam int               CNT_W      = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICK_DIV - 3);

   stateT            state_q,     state_d;
   logic [CNT_W-1:0] tickCnt_q,   tickCnt_d;
   logic [3:0]       codeNxt_q,   codeNxt_d;
   logic [3:0]       random_q,    random_d;
   logic             timerDone_q, timerDone_d;
   logic [15:0]      lfsrVal;
   logic [3:0]       codeSel;

   french_lfsr16 #(
      .SEED (LFSR_SEED)
   ) uLfsr (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .seed_load_i (seed_load),
      .seed_i      (seed_in),
      .lfsr_o      (lfsrVal)
   );

`ifdef FRENCH_CHASE_EN
   logic signed [11:0] dx, dy;
   logic        [11:0] absDx, absDy;
   logic               chaseHit;
   logic               unusedLfsrBits;

   // Chase draw: step along the dominant axis toward the frog (Y grows
   // downward); the low LFSR bits keep the code varied within its band.
   always_comb begin
      dx       = $signed({1'b0, frog_x}) - $signed({1'b0, obj_x});
      dy       = $signed({1'b0, frog_y}) - $signed({1'b0, obj_y});
      absDx    = dx[11] ? 12'(-dx) : 12'(dx);
      absDy    = dy[11] ? 12'(-dy) : 12'(dy);
      chaseHit = ({29'd0, lfsrVal[2:0]} < CHASE_NUM);
      codeSel  = lfsrVal[15:12];
      if (chaseHit) begin
         if ((absDx >= absDy) && (dx != 12'sd0)) begin
            codeSel = dirCode(dx[11] ? DIR_LEFT : DIR_RIGHT, lfsrVal[4:3]);
         end else if (dy != 12'sd0) begin
            codeSel = dirCode(dy[11] ? DIR_UP : DIR_DOWN, lfsrVal[4:3]);
         end
      end
   end

   assign unusedLfsrBits = ^lfsrVal[11:5];
`else
   logic unusedChase;

   assign codeSel     = lfsrVal[15:12];
   assign unusedChase = ^{frog_x, frog_y, obj_x, obj_y, lfsrVal[11:0]};
`endif

   // State, counter and registered outputs.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= IDLE;
         tickCnt_q   <= '0;
         codeNxt_q   <= CODE_RIGHT;
         random_q    <= CODE_RIGHT;
         timerDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tickCnt_q   <= tickCnt_d;
         codeNxt_q   <= codeNxt_d;
         random_q    <= random_d;
         timerDone_q <= timerDone_d;
      end
   end

   // Next state and tick counter; enable low always falls back to IDLE,
   // but FIRE still completes its pulse first.
   always_comb begin
      state_d   = state_q;
      tickCnt_d = tickCnt_q;
      case (state_q)
         IDLE: begin
            tickCnt_d = '0;
            if (enable) begin
               state_d   = COUNT;
               tickCnt_d = CNT_RELOAD;
            end
         end
         COUNT: begin
            if (!enable) begin
               state_d   = IDLE;
               tickCnt_d = '0;
            end else if (tickCnt_q == '0) begin
               state_d = DRAW;
            end else begin
               tickCnt_d = tickCnt_q - 1'b1;
            end
         end
         DRAW: begin
            state_d = enable ? FIRE : IDLE;
         end
         FIRE: begin
            if (enable) begin
               state_d   = COUNT;
               tickCnt_d = CNT_RELOAD;
            end else begin
               state_d   = IDLE;
               tickCnt_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            tickCnt_d = '0;
         end
      endcase
   end

   // Output values: the code is drawn in DRAW and published together with
   // the strobe on the edge that leaves FIRE.
   always_comb begin
      codeNxt_d   = codeNxt_q;
      random_d    = random_q;
      timerDone_d = 1'b0;
      if ((state_q == DRAW) && enable) begin
         codeNxt_d = codeSel;
      end
      if (state_q == FIRE) begin
         timerDone_d = 1'b1;
         random_d    = codeNxt_q;
      end
   end

   assign timer_done = timerDone_q;
   assign random     = random_q;

endmodule

// File: tb/tb_french_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_french_stim_gen
// Self-checking bench for french_stim_gen with TICK_DIV = 5. A behavioural
// model tracks the pulse schedule by counting cycles since enable rose and
// predicts each drawn code from its own LFSR copy.
// ---------------------------------------------------------------------------
module tb_french_stim_gen;
   import french_pkg::*;

   localparam int          TD      = 5;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam int          CHASE_N = 8;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        enable = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = 16'h0000;
   logic [10:0] frog_x = 11'd0, frog_y = 11'd0, obj_x = 11'd0, obj_y = 11'd0;
   logic        timer_done;
   logic [3:0]  random;

   int compared = 0;
   int mismatched = 0;

   french_stim_gen #(
      .TICK_DIV  (TD),
      .LFSR_SEED (SEED),
      .CHASE_NUM (CHASE_N)
   ) dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .enable     (enable),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .frog_x     (frog_x),
      .frog_y     (frog_y),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .timer_done (timer_done),
      .random     (random)
   );

   always #5 CLK = ~CLK;

   // Reference model
   function automatic logic [15:0] modelStep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic logic [3:0] modelCode(input logic [15:0] l,
                                            input logic [10:0] fx, input logic [10:0] fy,
                                            input logic [10:0] ox, input logic [10:0] oy);
`ifdef FRENCH_CHASE_EN
      int dx, dy, adx, ady, jit;
      dx  = int'(fx) - int'(ox);
      dy  = int'(fy) - int'(oy);
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      jit = int'(l[4:3]);
      if (int'(l[2:0]) < CHASE_N) begin
         if (adx >= ady && dx != 0) return (dx > 0) ? 4'(8 + jit) : 4'(12 + jit);
         if (dy != 0) return (dy > 0) ? 4'(4 + jit) : 4'(jit);
      end
`else
      if (^{fx, fy, ox, oy} === 1'bx) return 4'hx;
`endif
      return l[15:12];
   endfunction

   logic        mActive;
   int          mPhase;
   logic        mTd;
   logic [3:0]  mRand;
   logic [3:0]  mCodePrev;
   logic [15:0] mLfsr;

   // Pulses land every TD edges after the edge that first sees enable high;
   // the published code is the one drawn on the edge just before the pulse.
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         mActive   <= 1'b0;
         mPhase    <= 0;
         mTd       <= 1'b0;
         mRand     <= 4'd8;
         mCodePrev <= 4'd8;
         mLfsr     <= SEED;
      end else begin
         mTd <= 1'b0;
         if (!mActive) begin
            if (enable) begin
               mActive <= 1'b1;
               mPhase  <= 0;
            end
         end else begin
            if ((mPhase + 1) % TD == 0) begin
               mTd   <= 1'b1;
               mRand <= mCodePrev;
            end
            mPhase <= mPhase + 1;
            if (!enable) mActive <= 1'b0;
         end
         mCodePrev <= modelCode(mLfsr, frog_x, frog_y, obj_x, obj_y);
         mLfsr     <= seed_load ? ((seed_in == 16'h0000) ? SEED : seed_in) : modelStep(mLfsr);
      end
   end

   task automatic test_reset;
      RESETn = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_in = 16'h0000;
      repeat (3) @(negedge CLK);
      compared++; if (timer_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_td: got %0b want 0", timer_done); end
      compared++; if (random !== 4'd8) begin mismatched++; $display("[TB] FAIL reset_random: got %0d want 8", random); end
      compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("[TB] FAIL reset_state: got %0d want IDLE", dut.state_q); end
      compared++; if (dut.uLfsr.lfsr_o !== SEED) begin mismatched++; $display("[TB] FAIL reset_lfsr: got %h want %h", dut.uLfsr.lfsr_o, SEED); end
   endtask

   task automatic test_pulse_timing;
      RESETn = 1'b1;
      @(negedge CLK);
      enable = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge CLK);
         compared++;
         if (timer_done !== ((k % TD == 0) && (k != 0))) begin
            mismatched++; $display("[TB] FAIL pulse_k%0d: got %0b want %0b", k, timer_done, (k % TD == 0) && (k != 0));
         end
         compared++;
         if (random !== mRand) begin mismatched++; $display("[TB] FAIL pulse_random_k%0d: got %0d want %0d", k, random, mRand); end
      end
   endtask

   task automatic test_enable_drop;
      bit seen = 0;
      for (int i = 0; i < 3 * TD && !seen; i++) begin
         @(negedge CLK);
         if (timer_done) seen = 1;
      end
      compared++; if (!seen) begin mismatched++; $display("[TB] FAIL drop_wait: got no pulse want pulse"); end
      repeat (2) @(negedge CLK);
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         compared++; if (timer_done !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_td_%0d: got 1 want 0", i); end
         compared++; if (random !== mRand) begin mismatched++; $display("[TB] FAIL drop_hold_%0d: got %0d want %0d", i, random, mRand); end
      end
      enable = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge CLK);
         compared++;
         if (timer_done !== (k == TD)) begin mismatched++; $display("[TB] FAIL reenable_k%0d: got %0b want %0b", k, timer_done, k == TD); end
      end
   endtask

   task automatic test_seed;
      int pulses = 0;
      seed_load = 1'b1; seed_in = 16'h0000;
      @(negedge CLK);
      seed_load = 1'b0;
      compared++; if (dut.uLfsr.lfsr_o !== 16'hACE1) begin mismatched++; $display("[TB] FAIL seed_zero: got %h want ace1", dut.uLfsr.lfsr_o); end
      seed_load = 1'b1; seed_in = 16'h0001;
      @(negedge CLK);
      seed_load = 1'b0;
      compared++; if (dut.uLfsr.lfsr_o !== 16'h0001) begin mismatched++; $display("[TB] FAIL seed_one: got %h want 0001", dut.uLfsr.lfsr_o); end
      @(negedge CLK);
      compared++; if (dut.uLfsr.lfsr_o !== 16'hB400) begin mismatched++; $display("[TB] FAIL seed_step: got %h want b400", dut.uLfsr.lfsr_o); end
      enable = 1'b1;
      for (int i = 0; i < 3 * TD; i++) begin
         @(negedge CLK);
         if (mTd) pulses++;
         compared++; if (timer_done !== mTd) begin mismatched++; $display("[TB] FAIL seed_td_%0d: got %0b want %0b", i, timer_done, mTd); end
         compared++; if (random !== mRand) begin mismatched++; $display("[TB] FAIL seed_draw_%0d: got %0d want %0d", i, random, mRand); end
      end
      compared++; if (pulses < 2) begin mismatched++; $display("[TB] FAIL seed_draws: got %0d want >=2", pulses); end
   endtask

   task automatic test_reset_during_draw;
      bit seen = 0;
      enable = 1'b1;
      for (int i = 0; i < 3 * TD && !seen; i++) begin
         @(negedge CLK);
         if (timer_done) seen = 1;
      end
      compared++; if (!seen) begin mismatched++; $display("[TB] FAIL rdraw_wait: got no pulse want pulse"); end
      repeat (TD - 2) @(negedge CLK);
      compared++; if (dut.state_q !== DRAW) begin mismatched++; $display("[TB] FAIL rdraw_state: got %0d want DRAW", dut.state_q); end
      RESETn = 1'b0; enable = 1'b0;
      #1;
      compared++; if (timer_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rdraw_td: got %0b want 0", timer_done); end
      compared++; if (random !== 4'd8) begin mismatched++; $display("[TB] FAIL rdraw_random: got %0d want 8", random); end
      compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("[TB] FAIL rdraw_idle: got %0d want IDLE", dut.state_q); end
      @(negedge CLK);
      RESETn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         compared++; if (timer_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rdraw_stray_%0d: got 1 want 0", i); end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         compared++; if (timer_done !== mTd) begin mismatched++; $display("[TB] FAIL rnd_td_%0d: got %0b want %0b", i, timer_done, mTd); end
         compared++; if (random !== mRand) begin mismatched++; $display("[TB] FAIL rnd_code_%0d: got %0d want %0d", i, random, mRand); end
         compared++; if (dut.uLfsr.lfsr_o !== mLfsr) begin mismatched++; $display("[TB] FAIL rnd_lfsr_%0d: got %h want %h", i, dut.uLfsr.lfsr_o, mLfsr); end
         enable    = ($urandom_range(0, 24) != 0);
         seed_load = ($urandom_range(0, 19) == 0);
         seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         frog_x    = 11'($urandom); frog_y = 11'($urandom);
         obj_x     = 11'($urandom); obj_y  = 11'($urandom);
      end
      seed_load = 1'b0;
   endtask

`ifdef FRENCH_CHASE_EN
   task automatic test_chase_up;
      int pulses = 0;
      frog_x = 11'd300; frog_y = 11'd100; obj_x = 11'd200; obj_y = 11'd250;
      enable = 1'b1;
      repeat (2) @(negedge CLK);
      for (int i = 0; i < 4 * TD; i++) begin
         @(negedge CLK);
         if (timer_done && mTd) begin
            pulses++;
            compared++; if (random > 4'd3) begin mismatched++; $display("[TB] FAIL chase_up_%0d: got %0d want 0..3", i, random); end
            compared++; if (random !== mRand) begin mismatched++; $display("[TB] FAIL chase_up_model_%0d: got %0d want %0d", i, random, mRand); end
         end
      end
      compared++; if (pulses < 2) begin mismatched++; $display("[TB] FAIL chase_up_draws: got %0d want >=2", pulses); end
   endtask

   task automatic test_chase_equal;
      frog_x = 11'd200; frog_y = 11'd250; obj_x = 11'd200; obj_y = 11'd250;
      enable = 1'b1;
      for (int i = 0; i < 4 * TD; i++) begin
         @(negedge CLK);
         compared++; if (timer_done !== mTd) begin mismatched++; $display("[TB] FAIL chase_eq_td_%0d: got %0b want %0b", i, timer_done, mTd); end
         compared++; if (random !== mRand) begin mismatched++; $display("[TB] FAIL chase_eq_%0d: got %0d want %0d", i, random, mRand); end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_pulse_timing;
      test_enable_drop;
      test_seed;
      test_reset_during_draw;
      test_random;
`ifdef FRENCH_CHASE_EN
      test_chase_up;
      test_chase_equal;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/french_stim_gen.md
Name: french_stim_gen

Overview:
Stimulus source for the enemy-object mover. It produces the periodic `timer_done` strobe and the 4-bit `random` direction code that the mover consumes. The mover decodes `random` as: 0-3 UP, 4-7 DOWN, 8-11 RIGHT, 12-15 LEFT. The block sits between the game-control FSM (`enable`, seed) and the mover. In its optional chase mode it also reads frog and object coordinates.

Parameters:
- TICK_DIV, 833333, CLK cycles per `timer_done` pulse (60 Hz at 50 MHz); legal range is 3 or more.
- LFSR_SEED, 16'hACE1, LFSR reset value; also used whenever a zero seed is loaded.
- CHASE_NUM, 3, chase probability numerator out of 8; used only under CHASE_EN.

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous, active-low reset
- enable  in  1  game running; low freezes tick generation
- seed_load  in  1  one-cycle pulse: load `seed_in` into the LFSR
- seed_in  in  16  seed value
- frog_x  in  11  frog top-left X, in pixels
- frog_y  in  11  frog top-left Y, in pixels
- obj_x  in  11  enemy top-left X (mover's ObjectStartX)
- obj_y  in  11  enemy top-left Y (mover's ObjectStartY)
- timer_done  out  1  one-cycle tick strobe
- random  out  4  direction code; stable between ticks

Behaviour:
- Reset values:
  - `timer_done` = 0
  - `random` = 4'd8 (RIGHT)
  - LFSR = LFSR_SEED
  - tick counter = 0
  - state = IDLE
- LFSR:
  - 16-bit Galois, right shift, polynomial mask 16'hB400.
  - Advances every CLK regardless of `enable`, so player timing adds entropy.
  - `seed_load` overrides the advance that cycle. `seed_in` = 0 loads LFSR_SEED instead.
  - The LFSR is never zero.
- FSM states: IDLE, COUNT, DRAW, FIRE.
  - IDLE: counter = 0, `timer_done` = 0. If `enable` = 1, go to COUNT with counter = TICK_DIV-3.
  - COUNT: if `enable` = 0, go to IDLE. Else if counter = 0, go to DRAW. Else decrement the counter.
  - DRAW: capture the next code into an internal register `code_nxt`. If `enable` = 0, go to IDLE and discard the code. Else go to FIRE.
  - FIRE: `timer_done` = 1 for exactly this cycle and `random` <= `code_nxt`. Both are registered and change on the same edge. Then go to COUNT with counter = TICK_DIV-3, or to IDLE if `enable` = 0. The pulse completes regardless of `enable`.
- Timing:
  - While `enable` is held high, pulses are spaced exactly TICK_DIV cycles.
  - The first pulse is asserted TICK_DIV cycles after the edge on which `enable` was first sampled high.
- Code source, without chase: `code_nxt` = lfsr[15:12].
- `random` changes only on FIRE edges. It holds its value through IDLE and while `enable` is low.
- Reset mid-count: all registers return to their reset values immediately, and no partial pulse is emitted.
- `seed_load` during FIRE: the pulse and `random` are unaffected; the new seed affects only subsequent draws.

Optional Feature:
- Macro: FRENCH_CHASE_EN.
- Defined: in DRAW, if lfsr[2:0] < CHASE_NUM, a chase code is used instead of lfsr[15:12].
  - Compute dx = frog_x - obj_x and dy = frog_y - obj_y as 12-bit signed values.
  - If |dx| >= |dy| and dx != 0: RIGHT (8 + lfsr[4:3]) when dx > 0, else LEFT (12 + lfsr[4:3]).
  - Otherwise, if dy != 0: DOWN (4 + lfsr[4:3]) when dy > 0, else UP (0 + lfsr[4:3]). Y grows downward.
  - dx = dy = 0: fall back to lfsr[15:12].
- Undefined: the coordinate ports remain but are ignored, with no logic generated for them.

Decomposition:
- Package `french_pkg`:
  - direction enum (UP, DOWN, RIGHT, LEFT) and the base codes 0/4/8/12
  - COORD_W = 11
  - LFSR_POLY = 16'hB400
  - FSM state typedef
- Sub-module `french_lfsr16` contains the LFSR, seed load and zero-seed substitution. The top level holds the FSM, counter and code selection.

Test Plan:
1. Reset, then `enable` = 1 with TICK_DIV = 5 → `timer_done` pulses at cycles 5, 10, 15 after enable, each 1 cycle wide. `random` starts at 8 and changes only on the pulse edges.
2. Drop `enable` during COUNT with TICK_DIV = 5, two cycles before a pulse → no pulse occurs and `random` holds. Re-enabling gives the first pulse exactly 5 cycles later.
3. `seed_load` = 1 with `seed_in` = 0 → LFSR = 16'hACE1 the next cycle. With `seed_in` = 16'h0001, two draws match the golden model sequence.
4. Assert RESETn low during DRAW → `timer_done` = 0, `random` = 8, state = IDLE immediately, and no stray pulse after release.
5. With FRENCH_CHASE_EN, CHASE_NUM = 8, frog (300,100), obj (200,250) → |dy| = 150 > |dx| = 100, dy < 0, so every `random` is in 0-3 (UP).
6. With FRENCH_CHASE_EN, CHASE_NUM = 8, frog equal to obj (200,250) → `random` equals lfsr[15:12] of the model on each draw.
